simon_host_master: RTL and testbench

Initiator-side sequencer for the SIMON 64/128 cipher core. It accepts key-load and data-block requests from an upstream valid/ready source and drives the core's newKey/newData/readData handshake. It captures each result into a one-entry output register for a downstream valid/ready sink, and guards every core wait with a watchdog. It sits between the system bus adapter and the cipher core, one instance per core.

---
 rtl/simon_host_master.sv | 149 ++++++++++++++
 tb/tb_simon_host_master.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_host_master.sv
// Initiator-side sequencer for a SIMON 64/128 core: upstream key/block requests in,
// core newKey/newData/readData handshake out, one-entry result register with watchdog.
module simon_host_master #(
  parameter int N  = 32,
  parameter int M  = 4,
  parameter int TO = 255,
  parameter int Cw = 8
) (
  input  logic                  clk,
  input  logic                  R,
  input  logic [M-1:0][N-1:0]   key_in,
  input  logic                  key_valid,
  output logic                  key_ready,
  input  logic [2*N-1:0]        blk_in,
  input  logic                  blk_dec,
  input  logic                  blk_valid,
  output logic                  blk_ready,
  output logic                  newKey,
  output logic [M-1:0][N-1:0]   key,
  input  logic                  ldKey,
  input  logic                  doneKey,
  output logic                  newData,
  output logic [2*N-1:0]        plain,
  output logic                  enc_dec,
  input  logic                  ldData,
  input  logic                  doneData,
  input  logic [2*N-1:0]        cipher,
  output logic                  readData,
  output logic [2*N-1:0]        res,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE,
    KEY_REQ,
    KEY_WAIT,
    DATA_REQ,
    DATA_WAIT,
    READ
  } state_t;

  state_t          state;
  logic            key_loaded;
  logic [Cw-1:0]   wd_cnt;
  logic            wd_hit;

  assign wd_hit    = (wd_cnt == Cw'(TO));
  assign key_ready = (state == IDLE);
  // A waiting key always wins over a block, and a held result blocks new work.
  assign blk_ready = (state == IDLE) && key_loaded && !res_valid && !key_valid;
  assign newKey    = (state == KEY_REQ);
  assign newData   = (state == DATA_REQ);
  assign readData  = (state == READ);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (R) begin
      state      <= IDLE;
      key_loaded <= 1'b0;
      wd_cnt     <= '0;
      err        <= 1'b0;
      key        <= '0;
      plain      <= '0;
      enc_dec    <= 1'b0;
      res        <= '0;
      res_valid  <= 1'b0;
    end else begin
      if (res_valid && res_ready)
        res_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (key_valid) begin
            key    <= key_in;
            wd_cnt <= '0;
            state  <= KEY_REQ;
          end else if (blk_valid && blk_ready) begin
            plain   <= blk_in;
            enc_dec <= blk_dec;
            wd_cnt  <= '0;
            state   <= DATA_REQ;
          end
        end

        KEY_REQ: begin
          if (ldKey) begin
            wd_cnt <= '0;
            state  <= KEY_WAIT;
          end else if (wd_hit) begin
            err        <= 1'b1;
            key_loaded <= 1'b0;
            state      <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        KEY_WAIT: begin
          if (doneKey) begin
            key_loaded <= 1'b1;
            state      <= IDLE;
          end else if (wd_hit) begin
            err        <= 1'b1;
            key_loaded <= 1'b0;
            state      <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        DATA_REQ: begin
          if (ldData) begin
            wd_cnt <= '0;
            state  <= DATA_WAIT;
          end else if (wd_hit) begin
            err        <= 1'b1;
            key_loaded <= 1'b0;
            state      <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        // A timed-out block leaves res untouched so the last good result survives.
        DATA_WAIT: begin
          if (doneData) begin
            res       <= cipher;
            res_valid <= 1'b1;
            state     <= READ;
          end else if (wd_hit) begin
            err        <= 1'b1;
            key_loaded <= 1'b0;
            state      <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        READ: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_host_master.sv
// Directed + randomized bench for simon_host_master; a behavioural core stub answers
// the handshake and a small model tracks key, result and key-loaded status.
module tb_simon_host_master;

  localparam int N  = 32;
  localparam int M  = 4;
  localparam int TO = 255;
  localparam int CW = 8;

  localparam logic [127:0] K0 = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [63:0]  P0 = 64'h656b696c_20646e75;
  localparam logic [63:0]  C0 = 64'h44c8fc20_b9dfa07a;

  logic                clk = 1'b0;
  logic                R;
  logic [M-1:0][N-1:0] key_in;
  logic                key_valid;
  logic                key_ready;
  logic [2*N-1:0]      blk_in;
  logic                blk_dec;
  logic                blk_valid;
  logic                blk_ready;
  logic                newKey;
  logic [M-1:0][N-1:0] key;
  logic                ldKey;
  logic                doneKey;
  logic                newData;
  logic [2*N-1:0]      plain;
  logic                enc_dec;
  logic                ldData;
  logic                doneData;
  logic [2*N-1:0]      cipher;
  logic                readData;
  logic [2*N-1:0]      res;
  logic                res_valid;
  logic                res_ready;
  logic                busy;
  logic                err;

  int           vectors = 0;
  int           miscompares = 0;
  logic [127:0] model_key;
  logic [63:0]  model_res;

  simon_host_master #(.N(N), .M(M), .TO(TO), .Cw(CW)) dut (
    .clk(clk), .R(R),
    .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .blk_in(blk_in), .blk_dec(blk_dec), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .newKey(newKey), .key(key), .ldKey(ldKey), .doneKey(doneKey),
    .newData(newData), .plain(plain), .enc_dec(enc_dec), .ldData(ldData),
    .doneData(doneData), .cipher(cipher), .readData(readData),
    .res(res), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Stand-in for the cipher core: the published SIMON 64/128 vector for K0, a toy mix otherwise.
  function automatic logic [63:0] core_fn(input logic [127:0] k, input logic [63:0] p, input logic d);
    logic [63:0] mix;
    if (k == K0 && !d && p == P0) return C0;
    if (k == K0 && d && p == C0) return P0;
    mix = k[127:64] ^ {k[31:0], k[63:32]};
    return d ? ({p[31:0], p[63:32]} ^ mix) : ({p[31:0], p[63:32]} ^ ~mix);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] k, input int ld_lat, input int done_lat);
    key_in    = k;
    key_valid = 1'b1;
    #1;
    check_output("key_ready", key_ready, 1);
    check_output("blk_ready_vs_key", blk_ready, 0);
    cyc();
    key_valid = 1'b0;
    key_in    = {$urandom, $urandom, $urandom, $urandom};
    model_key = k;
    for (int i = 0; i < ld_lat; i++) begin
      check_output("newKey_hold", newKey, 1);
      cyc();
    end
    check_output("newKey", newKey, 1);
    check_output("newData_during_key", newData, 0);
    check_output("key_out", key, k);
    ldKey = 1'b1;
    cyc();
    ldKey = 1'b0;
    check_output("newKey_drop", newKey, 0);
    check_output("key_wait_busy", busy, 1);
    for (int i = 0; i < done_lat; i++) cyc();
    doneKey = 1'b1;
    cyc();
    doneKey = 1'b0;
    check_output("key_done_idle", busy, 0);
  endtask

  task automatic run_block(input logic [63:0] p, input logic d, input int ld_lat, input int done_lat);
    logic [63:0] exp_res;
    exp_res   = core_fn(model_key, p, d);
    blk_in    = p;
    blk_dec   = d;
    blk_valid = 1'b1;
    #1;
    check_output("blk_ready", blk_ready, 1);
    cyc();
    blk_valid = 1'b0;
    blk_in    = {$urandom, $urandom};
    for (int i = 0; i < ld_lat; i++) begin
      check_output("newData_hold", newData, 1);
      cyc();
    end
    check_output("newData", newData, 1);
    check_output("plain", plain, p);
    check_output("enc_dec", enc_dec, d);
    ldData = 1'b1;
    cyc();
    ldData = 1'b0;
    check_output("newData_drop", newData, 0);
    for (int i = 0; i < done_lat; i++) begin
      check_output("readData_early", readData, 0);
      cyc();
    end
    cipher   = core_fn(key, plain, enc_dec);
    doneData = 1'b1;
    cyc();
    doneData = 1'b0;
    cipher   = {$urandom, $urandom};
    check_output("readData_pulse", readData, 1);
    check_output("res", res, exp_res);
    check_output("res_valid_set", res_valid, 1);
    cyc();
    check_output("readData_single", readData, 0);
    check_output("idle_after_read", busy, 0);
    check_output("res_valid_held", res_valid, 1);
    check_output("blk_ready_pending", blk_ready, 0);
    model_res = exp_res;
  endtask

  task automatic consume(input int hold);
    for (int i = 0; i < hold; i++) begin
      res_ready = 1'b0;
      check_output("res_valid_wait", res_valid, 1);
      check_output("res_hold", res, model_res);
      check_output("blk_ready_held", blk_ready, 0);
      cyc();
    end
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    check_output("res_valid_clear", res_valid, 0);
    check_output("res_kept", res, model_res);
  endtask

  initial begin
    logic [127:0] rk;
    R = 1'b1;
    key_in = '0; key_valid = 1'b0; blk_in = '0; blk_dec = 1'b0; blk_valid = 1'b0;
    ldKey = 1'b0; doneKey = 1'b0; ldData = 1'b0; doneData = 1'b0; cipher = '0; res_ready = 1'b0;
    model_key = '0;
    model_res = '0;
    cyc();
    cyc();
    check_output("rst_newKey", newKey, 0);
    check_output("rst_newData", newData, 0);
    check_output("rst_readData", readData, 0);
    check_output("rst_key", key, 0);
    check_output("rst_plain", plain, 0);
    check_output("rst_enc_dec", enc_dec, 0);
    check_output("rst_res", res, 0);
    check_output("rst_res_valid", res_valid, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_err", err, 0);
    check_output("rst_blk_ready", blk_ready, 0);
    R = 1'b0;

    // Block offered before any key: must stall, then lose to a simultaneous key.
    blk_in    = P0;
    blk_dec   = 1'b0;
    blk_valid = 1'b1;
    #1;
    check_output("no_key_blk_ready", blk_ready, 0);
    cyc();
    check_output("no_key_stall", busy, 0);
    load_key(K0, 3, 4);
    run_block(P0, 1'b0, 2, 5);
    consume(3);
    run_block(C0, 1'b1, 0, 3);
    consume(0);

    for (int it = 0; it < 8; it++) begin
      run_block({$urandom, $urandom}, 1'($urandom_range(0, 1)),
                $urandom_range(0, 4), $urandom_range(0, 6));
      if ($urandom_range(0, 1) == 1) begin
        rk = {$urandom, $urandom, $urandom, $urandom};
        load_key(rk, $urandom_range(0, 3), $urandom_range(0, 5));
        check_output("res_across_key", res, model_res);
        check_output("res_valid_across_key", res_valid, 1);
      end
      consume($urandom_range(0, 3));
    end

    // Core never reports doneData: watchdog fires 256 cycles after DATA_WAIT entry.
    blk_in    = {$urandom, $urandom};
    blk_valid = 1'b1;
    #1;
    check_output("wd_blk_ready", blk_ready, 1);
    cyc();
    blk_valid = 1'b0;
    ldData    = 1'b1;
    cyc();
    ldData    = 1'b0;
    for (int i = 0; i < TO; i++) begin
      cipher = {$urandom, $urandom};
      cyc();
    end
    check_output("wd_err_early", err, 0);
    check_output("wd_busy_early", busy, 1);
    cyc();
    check_output("wd_err", err, 1);
    check_output("wd_idle", busy, 0);
    check_output("wd_res_untouched", res, model_res);
    check_output("wd_res_valid", res_valid, 0);
    blk_valid = 1'b1;
    #1;
    check_output("wd_blk_ready", blk_ready, 0);
    cyc();
    blk_valid = 1'b0;
    check_output("wd_stall", busy, 0);

    load_key(K0, 0, 0);
    check_output("err_sticky", err, 1);
    run_block(P0, 1'b0, 0, 0);
    consume(1);

    // Reset in the middle of DATA_WAIT.
    blk_in    = C0;
    blk_dec   = 1'b1;
    blk_valid = 1'b1;
    cyc();
    blk_valid = 1'b0;
    ldData    = 1'b1;
    cyc();
    ldData    = 1'b0;
    cyc();
    cyc();
    R = 1'b1;
    cyc();
    R = 1'b0;
    check_output("abort_newKey", newKey, 0);
    check_output("abort_newData", newData, 0);
    check_output("abort_readData", readData, 0);
    check_output("abort_key", key, 0);
    check_output("abort_plain", plain, 0);
    check_output("abort_enc_dec", enc_dec, 0);
    check_output("abort_res", res, 0);
    check_output("abort_res_valid", res_valid, 0);
    check_output("abort_busy", busy, 0);
    check_output("abort_err", err, 0);
    blk_valid = 1'b1;
    #1;
    check_output("abort_key_unloaded", blk_ready, 0);
    cyc();
    blk_valid = 1'b0;
    check_output("abort_stall", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
